// File: rtl/sd_arb_pkg.sv
// Shared types and defaults for the SD sector arbiter.
package sd_arb_pkg;

   localparam int BK_SECTORS_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_XFER  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CD = 1'b0,
      OWN_BK = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/sd_sector_arbiter.sv
// Shares one hps_io SD sector port between the CD reader and the
// backup-RAM load/save engine, one sector at a time.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | between sectors; pick owner (CD first), latch sd_lba
//  ST_ISSUE | sd_rd / sd_wr held until hps_io raises sd_ack
//  ST_XFER  | sector words moving; ends when sd_ack falls
//  ST_DONE  | one cycle: cd_done pulse or backup sector counter advance
module sd_sector_arbiter
   import sd_arb_pkg::*;
#(
   parameter int BK_SECTORS = BK_SECTORS_DEF,
   parameter int LBA_W      = 32
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic [LBA_W-1:0] cd_lba,
   input  logic             cd_rd,
   output logic             cd_done,
   output logic             cd_buff_wr,
   input  logic             bk_ena,
   input  logic             bk_load,
   input  logic             bk_save,
   output logic             bk_busy,
   output logic             bk_loading,
   output logic             bk_buff_wr,
   output logic [11:0]      bk_buff_addr,
   output logic [LBA_W-1:0] sd_lba,
   output logic             sd_rd,
   output logic             sd_wr,
   input  logic             sd_ack,
   input  logic [7:0]       sd_buff_addr,
   input  logic             sd_buff_wr
);

   localparam int CNT_W = (BK_SECTORS > 1) ? $clog2(BK_SECTORS) : 1;
   localparam logic [CNT_W-1:0] LAST_SECTOR = CNT_W'(BK_SECTORS - 1);

   arb_state_t       state;
   arb_state_t       state_nxt;
   arb_owner_t       owner;
   logic [CNT_W-1:0] bk_sector;
   logic             bk_load_q;
   logic             bk_save_q;
   logic             bk_start;
   logic             bk_sector_end;
   logic             in_xfer;

   // A new backup operation needs a fresh edge while idle and enabled.
   assign bk_start      = ((bk_load & ~bk_load_q) | (bk_save & ~bk_save_q))
                          & bk_ena & ~bk_busy;
   assign bk_sector_end = (state == ST_DONE) && (owner == OWN_BK);
   assign in_xfer       = (state == ST_XFER) && sd_ack;

   // Buffer writes are steered to whoever owns the sector in flight.
   assign cd_buff_wr   = sd_buff_wr & in_xfer & (owner == OWN_CD);
   assign bk_buff_wr   = sd_buff_wr & in_xfer & (owner == OWN_BK) & bk_loading;
   assign bk_buff_addr = {4'(bk_sector), sd_buff_addr};

   // State register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and request/handshake outputs.
   always_comb begin
      state_nxt = state;
      sd_rd     = 1'b0;
      sd_wr     = 1'b0;
      cd_done   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cd_rd || bk_busy) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            sd_rd = (owner == OWN_CD) || bk_loading;
            sd_wr = (owner == OWN_BK) && !bk_loading;
            if (sd_ack) begin
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (!sd_ack) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            cd_done   = (owner == OWN_CD);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Owner and LBA are re-chosen every idle cycle and frozen otherwise.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         owner  <= OWN_CD;
         sd_lba <= '0;
      end else if (state == ST_IDLE) begin
         if (cd_rd) begin
            owner  <= OWN_CD;
            sd_lba <= cd_lba;
         end else begin
            owner  <= OWN_BK;
            sd_lba <= LBA_W'(bk_sector);
         end
      end
   end

   // Backup operation tracking: edge detect, busy flag, sector counter.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bk_load_q  <= 1'b0;
         bk_save_q  <= 1'b0;
         bk_busy    <= 1'b0;
         bk_loading <= 1'b0;
         bk_sector  <= '0;
      end else begin
         bk_load_q <= bk_load;
         bk_save_q <= bk_save;
         if (bk_start) begin
            bk_busy    <= 1'b1;
            bk_loading <= bk_load;
            bk_sector  <= '0;
         end else if (bk_sector_end) begin
            bk_sector <= bk_sector + CNT_W'(1);
            if (bk_sector == LAST_SECTOR) begin
               bk_busy    <= 1'b0;
               bk_loading <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Randomized bench for sd_sector_arbiter: an hps_io responder serves every
// sector and checks it against a request-level model of who should own it.
module tb_sd_sector_arbiter;

   localparam int BK_SECTORS = 16;
   localparam int LBA_W      = 32;
   localparam int WORDS      = 256;

   logic             clk_sys = 1'b0;
   logic             reset_n;
   logic [LBA_W-1:0] cd_lba;
   logic             cd_rd;
   logic             cd_done;
   logic             cd_buff_wr;
   logic             bk_ena;
   logic             bk_load;
   logic             bk_save;
   logic             bk_busy;
   logic             bk_loading;
   logic             bk_buff_wr;
   logic [11:0]      bk_buff_addr;
   logic [LBA_W-1:0] sd_lba;
   logic             sd_rd;
   logic             sd_wr;
   logic             sd_ack;
   logic [7:0]       sd_buff_addr;
   logic             sd_buff_wr;

   int checks   = 0;
   int failures = 0;

   // model state owned by the main sequence
   bit bk_active = 1'b0;
   int bk_base   = 0;
   bit bk_load_m = 1'b0;
   // model state owned by the hps_io responder
   int          bk_done_cnt  = 0;
   int          sector_total = 0;
   bit          in_sector    = 1'b0;
   bit          cur_is_cd    = 1'b0;
   int          word_idx     = 0;
   int unsigned addr_hits [4096];

   logic             cd_rd_smp;
   logic [LBA_W-1:0] cd_lba_smp;

   sd_sector_arbiter #(.BK_SECTORS(BK_SECTORS), .LBA_W(LBA_W)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .cd_lba       (cd_lba),
      .cd_rd        (cd_rd),
      .cd_done      (cd_done),
      .cd_buff_wr   (cd_buff_wr),
      .bk_ena       (bk_ena),
      .bk_load      (bk_load),
      .bk_save      (bk_save),
      .bk_busy      (bk_busy),
      .bk_loading   (bk_loading),
      .bk_buff_wr   (bk_buff_wr),
      .bk_buff_addr (bk_buff_addr),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .sd_ack       (sd_ack),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_wr   (sd_buff_wr)
   );

   always #5 clk_sys = ~clk_sys;

   // CD request as seen by the arbiter at each edge (the grant edge matters).
   always @(posedge clk_sys) begin
      cd_rd_smp  <= cd_rd;
      cd_lba_smp <= cd_lba;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // A backup operation is in progress until BK_SECTORS of its sectors are done.
   function automatic bit model_busy();
      return bk_active && ((bk_done_cnt - bk_base) < BK_SECTORS);
   endfunction

   task automatic drop_bus();
      sd_ack     = 1'b0;
      sd_buff_wr = 1'b0;
      in_sector  = 1'b0;
   endtask

   // Called on the first negedge where sd_rd/sd_wr is seen.
   task automatic serve_sector();
      bit               exp_cd;
      bit               exp_rd;
      bit               exp_bk_ld;
      logic [LBA_W-1:0] exp_lba;
      logic [LBA_W-1:0] lba_hold;
      int               cd_cnt;
      int               bk_cnt;
      int               d;
      exp_cd = cd_rd_smp;
      if (exp_cd) begin
         exp_lba = cd_lba_smp;
         exp_rd  = 1'b1;
      end else begin
         check_val("bk_pending", 32'(model_busy()), 32'd1);
         exp_lba = bk_done_cnt - bk_base;
         exp_rd  = bk_load_m;
      end
      exp_bk_ld = !exp_cd && exp_rd;
      check_val("sd_lba", sd_lba, exp_lba);
      check_val("sd_rd", 32'(sd_rd), 32'(exp_rd));
      check_val("sd_wr", 32'(sd_wr), 32'(!exp_rd));
      check_val("rd_wr_excl", 32'(sd_rd & sd_wr), 32'd0);
      if (exp_bk_ld && exp_lba == 0) begin
         foreach (addr_hits[i]) addr_hits[i] = 0;
      end
      in_sector = 1'b1;
      cur_is_cd = exp_cd;
      word_idx  = 0;
      lba_hold  = sd_lba;
      d = $urandom_range(0, 3);
      repeat (d) begin
         @(negedge clk_sys);
         if (!reset_n) begin drop_bus(); return; end
         check_val("req_hold", 32'(sd_rd | sd_wr), 32'd1);
      end
      // spurious strobe while the arbiter is still in its issue phase
      sd_ack       = 1'b1;
      sd_buff_wr   = 1'b1;
      sd_buff_addr = 8'hA5;
      #1;
      check_val("wr_before_xfer", 32'({cd_buff_wr, bk_buff_wr}), 32'd0);
      @(negedge clk_sys);
      if (!reset_n) begin drop_bus(); return; end
      sd_buff_wr = 1'b0;
      #1;
      check_val("req_drop", 32'(sd_rd | sd_wr), 32'd0);
      cd_cnt = 0;
      bk_cnt = 0;
      for (int w = 0; w < WORDS; w++) begin
         @(negedge clk_sys);
         if (!reset_n) begin drop_bus(); return; end
         if ($urandom_range(0, 7) == 0) begin
            sd_buff_wr = 1'b0;
            #1;
            cd_cnt += int'(cd_buff_wr);
            bk_cnt += int'(bk_buff_wr);
            @(negedge clk_sys);
            if (!reset_n) begin drop_bus(); return; end
         end
         sd_buff_addr = w[7:0];
         sd_buff_wr   = 1'b1;
         word_idx     = w;
         #1;
         cd_cnt += int'(cd_buff_wr);
         bk_cnt += int'(bk_buff_wr);
         if (bk_buff_wr) addr_hits[bk_buff_addr]++;
         if (exp_bk_ld) check_val("bk_buff_addr", 32'(bk_buff_addr), exp_lba * 256 + w);
      end
      @(negedge clk_sys);
      if (!reset_n) begin drop_bus(); return; end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      check_val("cd_wr_count", cd_cnt, exp_cd ? WORDS : 0);
      check_val("bk_wr_count", bk_cnt, exp_bk_ld ? WORDS : 0);
      @(negedge clk_sys);
      if (!reset_n) begin drop_bus(); return; end
      check_val("cd_done", 32'(cd_done), 32'(exp_cd));
      check_val("lba_stable", sd_lba, lba_hold);
      sector_total++;
      if (!exp_cd) bk_done_cnt++;
      @(negedge clk_sys);
      if (!reset_n) begin drop_bus(); return; end
      check_val("cd_done_1cyc", 32'(cd_done), 32'd0);
      check_val("bk_busy", 32'(bk_busy), 32'(model_busy()));
      check_val("bk_loading", 32'(bk_loading), 32'(model_busy() && bk_load_m));
      in_sector = 1'b0;
   endtask

   // hps_io responder
   initial begin : hps_model
      sd_ack       = 1'b0;
      sd_buff_wr   = 1'b0;
      sd_buff_addr = 8'h00;
      forever begin
         @(negedge clk_sys);
         if (reset_n && (sd_rd || sd_wr)) serve_sector();
      end
   end

   task automatic cd_start(input logic [LBA_W-1:0] lba);
      cd_lba = lba;
      cd_rd  = 1'b1;
   endtask

   task automatic cd_wait();
      int n = 0;
      while (cd_done !== 1'b1 && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      check_val("cd_done_seen", 32'(cd_done), 32'd1);
      cd_rd = 1'b0;
   endtask

   task automatic bk_pulse(input bit ld, input bit sv);
      if (bk_ena && !model_busy() && (ld || sv)) begin
         bk_active = 1'b1;
         bk_base   = bk_done_cnt;
         bk_load_m = ld;
      end
      bk_load = ld;
      bk_save = sv;
      @(negedge clk_sys);
      bk_load = 1'b0;
      bk_save = 1'b0;
      check_val("bk_busy_start", 32'(bk_busy), 32'(model_busy()));
      check_val("bk_loading_start", 32'(bk_loading), 32'(model_busy() && bk_load_m));
   endtask

   task automatic wait_bk_sector(input int idx);
      int n = 0;
      while (!(in_sector && !cur_is_cd && (bk_done_cnt - bk_base) == idx && word_idx >= 20)
             && n < 12000) begin
         @(negedge clk_sys);
         n++;
      end
      check_val("bk_reach_sector", 32'(n < 12000), 32'd1);
   endtask

   task automatic bk_wait_idle();
      int n = 0;
      while (bk_busy !== 1'b0 && n < 12000) begin
         @(negedge clk_sys);
         n++;
      end
      check_val("bk_finish", 32'(bk_busy), 32'd0);
      check_val("bk_sectors", bk_done_cnt - bk_base, BK_SECTORS);
   endtask

   initial begin : main
      int n;
      int k;
      int st;
      bit seen;
      reset_n = 1'b0;
      cd_rd   = 1'b0;
      cd_lba  = '0;
      bk_ena  = 1'b0;
      bk_load = 1'b0;
      bk_save = 1'b0;
      #2;
      check_val("rst_sd_rd", 32'(sd_rd), 32'd0);
      check_val("rst_sd_wr", 32'(sd_wr), 32'd0);
      check_val("rst_sd_lba", sd_lba, 32'd0);
      check_val("rst_cd_done", 32'(cd_done), 32'd0);
      check_val("rst_bk_busy", 32'(bk_busy), 32'd0);
      check_val("rst_bk_loading", 32'(bk_loading), 32'd0);
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);

      // single CD sector at a known LBA, then a few random ones
      cd_start(32'h0000_1234);
      cd_wait();
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk_sys);
         cd_start($urandom);
         cd_wait();
      end

      // backup save, with ignored save/load edges while busy
      bk_ena = 1'b1;
      bk_pulse(1'b0, 1'b1);
      wait_bk_sector(3);
      bk_pulse(1'b0, 1'b1);
      wait_bk_sector(9);
      bk_pulse(1'b1, 1'b0);
      bk_wait_idle();

      // save with the image disabled does nothing
      repeat (2) @(negedge clk_sys);
      bk_ena = 1'b0;
      st = sector_total;
      bk_pulse(1'b0, 1'b1);
      repeat (20) @(negedge clk_sys);
      check_val("no_sector_ena0", sector_total, st);
      check_val("bk_idle_ena0", 32'(bk_busy), 32'd0);
      bk_ena = 1'b1;

      // backup load with CD sectors interleaved
      bk_pulse(1'b1, 1'b0);
      wait_bk_sector(5);
      cd_start($urandom);
      cd_wait();
      k = $urandom_range(7, 14);
      wait_bk_sector(k);
      cd_start($urandom);
      cd_wait();
      bk_wait_idle();
      n = 0;
      foreach (addr_hits[i]) if (addr_hits[i] == 1) n++;
      check_val("addr_cover", n, 4096);

      // CD and a combined load+save edge in the same cycle
      repeat (2) @(negedge clk_sys);
      cd_start($urandom);
      bk_pulse(1'b1, 1'b1);
      cd_wait();
      bk_wait_idle();

      // reset in the middle of a CD transfer
      repeat (2) @(negedge clk_sys);
      cd_start($urandom | 32'h1);
      n = 0;
      while (!(in_sector && cur_is_cd && word_idx >= 10) && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      check_val("xfer_reached", 32'(n < 3000), 32'd1);
      #3;
      reset_n = 1'b0;
      cd_rd   = 1'b0;
      #1;
      check_val("arst_sd_rd", 32'(sd_rd), 32'd0);
      check_val("arst_sd_wr", 32'(sd_wr), 32'd0);
      check_val("arst_cd_done", 32'(cd_done), 32'd0);
      check_val("arst_cd_buff_wr", 32'(cd_buff_wr), 32'd0);
      check_val("arst_bk_buff_wr", 32'(bk_buff_wr), 32'd0);
      check_val("arst_bk_busy", 32'(bk_busy), 32'd0);
      check_val("arst_bk_loading", 32'(bk_loading), 32'd0);
      check_val("arst_sd_lba", sd_lba, 32'd0);
      bk_active = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk_sys);
         if (cd_done || sd_rd || sd_wr) seen = 1'b1;
      end
      check_val("quiet_after_rst", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
